multicycle_sequencer: RTL and testbench

Multicycle control FSM for the processor datapath. It replaces the ad-hoc two-phase lw/sw handling with one explicit state machine that sequences fetch, decode, execute, memory and write-back. Instruction and data share a single memory port with a variable-latency req/ready handshake. The block drives every datapath select and enable from the current state and the latched instruction word.

---
 rtl/ctrl_pkg.sv | 43 ++++
 rtl/op_classify.sv | 23 ++
 rtl/multicycle_sequencer.sv | 167 ++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: opcodes, states, datapath mux
// selects and the opclass one-hot produced by op_classify.
package ctrl_pkg;

   localparam logic [5:0] OP_AND  = 6'b100000;
   localparam logic [5:0] OP_NOR  = 6'b100110;
   localparam logic [5:0] OP_NOT  = 6'b000100;
   localparam logic [5:0] OP_ROLV = 6'b000000;
   localparam logic [5:0] OP_RORV = 6'b000010;
   localparam logic [5:0] OP_NORI = 6'b001110;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BLEU = 6'b010000;
   localparam logic [5:0] OP_JR   = 6'b001000;
   localparam logic [5:0] OP_JAL  = 6'b000011;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_JUMP   = 2'b01;
   localparam logic [1:0] PC_BRANCH = 2'b10;
   localparam logic [1:0] PC_REG    = 2'b11;

   typedef enum logic [3:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM_ADDR,
      S_MEM_ACC, S_WB, S_BRANCH, S_JUMP
   } state_t;

   typedef struct packed {
      logic rtype;
      logic itype;
      logic load;
      logic store;
      logic branch;
      logic jr;
      logic jal;
      logic illegal;
   } opclass_t;

endpackage

// File: rtl/op_classify.sv
// Combinational opcode decoder: maps ins[31:26] onto exactly one opclass bit.
module op_classify
   import ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   output opclass_t   opclass
);

   always_comb begin
      opclass = '0;
      case (opcode)
         OP_AND, OP_NOR, OP_NOT, OP_ROLV, OP_RORV: opclass.rtype  = 1'b1;
         OP_NORI:                                  opclass.itype  = 1'b1;
         OP_LW:                                    opclass.load   = 1'b1;
         OP_SW:                                    opclass.store  = 1'b1;
         OP_BLEU:                                  opclass.branch = 1'b1;
         OP_JR:                                    opclass.jr     = 1'b1;
         OP_JAL:                                   opclass.jal    = 1'b1;
         default:                                  opclass.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/write-back over a
// shared variable-latency memory port, with a bounded wait that aborts to FETCH.
module multicycle_sequencer
   import ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] ins,
   input  logic        mem_ready,
   input  logic        branch_cond,
   output logic        mem_req,
   output logic        PCWrite,
   output logic        IorD,
   output logic        IRWrite,
   output logic        memWrite,
   output logic        regWriteEnable,
   output logic        memToReg,
   output logic        regDst,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  PCSrc,
   output logic [4:0]  ALUControl,
   output logic        instr_done,
   output logic        illegal_op,
   output logic        mem_timeout
);

   localparam logic [7:0] LIMIT = WAIT_LIMIT[7:0];

   state_t     state_reg, state_next;
   logic [7:0] wait_cnt_reg, wait_cnt_next;
   opclass_t   cls;
   logic       timed_out;
   logic       unused_ins_bits;

   assign unused_ins_bits = ^ins[25:0];

   op_classify u_classify (
      .opcode  (ins[31:26]),
      .opclass (cls)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= S_RST;
         wait_cnt_reg <= 8'd0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   // The timeout cycle itself is request-free, so a late mem_ready there is ignored.
   assign timed_out = (state_reg == S_FETCH || state_reg == S_MEM_ACC) &&
                      (wait_cnt_reg == LIMIT);

   always_comb begin
      state_next     = state_reg;
      mem_req        = 1'b0;
      PCWrite        = 1'b0;
      IorD           = 1'b0;
      IRWrite        = 1'b0;
      memWrite       = 1'b0;
      regWriteEnable = 1'b0;
      memToReg       = 1'b0;
      regDst         = 1'b0;
      ALUSrcA        = 1'b0;
      ALUSrcB        = SRCB_REG;
      PCSrc          = PC_ALU;
      ALUControl     = 5'b00000;
      instr_done     = 1'b0;
      illegal_op     = 1'b0;
      mem_timeout    = 1'b0;
      case (state_reg)
         S_RST: state_next = S_FETCH;
         S_FETCH: begin
            if (timed_out) begin
               mem_timeout = 1'b1;
               state_next  = S_FETCH;
            end else begin
               mem_req = 1'b1;
               ALUSrcB = SRCB_FOUR;
               if (mem_ready) begin
                  IRWrite    = 1'b1;
                  PCWrite    = 1'b1;
                  state_next = S_DECODE;
               end
            end
         end
         S_DECODE: begin
            ALUSrcB = SRCB_IMM_SH;
            if (cls.rtype || cls.itype)     state_next = S_EXEC;
            else if (cls.load || cls.store) state_next = S_MEM_ADDR;
            else if (cls.branch)            state_next = S_BRANCH;
            else if (cls.jr || cls.jal)     state_next = S_JUMP;
            else begin
               illegal_op = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = cls.itype ? SRCB_IMM : SRCB_REG;
            ALUControl = ins[31:27];
            state_next = S_WB;
         end
         S_WB: begin
            regWriteEnable = 1'b1;
            memToReg       = cls.load;
            regDst         = cls.rtype;
            instr_done     = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEM_ADDR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = ins[31:27];
            state_next = S_MEM_ACC;
         end
         S_MEM_ACC: begin
            if (timed_out) begin
               mem_timeout = 1'b1;
               state_next  = S_FETCH;
            end else begin
               mem_req  = 1'b1;
               IorD     = 1'b1;
               memWrite = cls.store;
               if (mem_ready) begin
                  if (cls.load) begin
                     state_next = S_WB;
                  end else begin
                     instr_done = 1'b1;
                     state_next = S_FETCH;
                  end
               end
            end
         end
         S_BRANCH: begin
            PCWrite    = branch_cond;
            PCSrc      = PC_BRANCH;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_JUMP: begin
            PCWrite        = 1'b1;
            PCSrc          = cls.jr ? PC_REG : PC_JUMP;
            regWriteEnable = cls.jal;
            memToReg       = cls.jal;
            instr_done     = 1'b1;
            state_next     = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Cleared on every state entry (and on a timeout re-entry of FETCH).
   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (state_next != state_reg || timed_out)
         wait_cnt_next = 8'd0;
      else if (mem_req && !mem_ready)
         wait_cnt_next = wait_cnt_reg + 8'd1;
   end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: each directed instruction pushes its expected retire record;
// a negedge monitor accumulates per-instruction observations and checks on retire.
module tb_multicycle_sequencer;

   localparam int K_DONE = 0, K_ILL = 1, K_TO = 2, K_ABORT = 3;
   localparam int NV = 13;

   typedef struct {
      logic [31:0] ins;
      int fw, dw;
      logic bc;
      int kind, lat, dreq, mw, rwe, pcw, irw, pcsrc, m2r, rdst;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic [31:0] ins = 32'h0;
   logic mem_ready = 1'b0;
   logic branch_cond = 1'b0;
   logic mem_req, PCWrite, IorD, IRWrite, memWrite, regWriteEnable, memToReg, regDst, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [4:0] ALUControl;
   logic instr_done, illegal_op, mem_timeout;

   int tests = 0;
   int fails = 0;
   int fetch_wait = 0;
   int data_wait = 0;
   vec_t vecs [NV];
   vec_t sb [$];

   multicycle_sequencer #(.WAIT_LIMIT(255)) dut (
      .clock(clk), .reset_n(reset_n), .ins(ins), .mem_ready(mem_ready),
      .branch_cond(branch_cond), .mem_req(mem_req), .PCWrite(PCWrite), .IorD(IorD),
      .IRWrite(IRWrite), .memWrite(memWrite), .regWriteEnable(regWriteEnable),
      .memToReg(memToReg), .regDst(regDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .PCSrc(PCSrc), .ALUControl(ALUControl), .instr_done(instr_done),
      .illegal_op(illegal_op), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic [31:0] i, int fw, int dw, logic bc, int kind, int lat,
                               int dreq, int mw, int rwe, int pcw, int irw, int pcsrc,
                               int m2r, int rdst);
      vec_t v;
      v.ins = i; v.fw = fw; v.dw = dw; v.bc = bc; v.kind = kind; v.lat = lat;
      v.dreq = dreq; v.mw = mw; v.rwe = rwe; v.pcw = pcw; v.irw = irw;
      v.pcsrc = pcsrc; v.m2r = m2r; v.rdst = rdst;
      return v;
   endfunction

   function automatic void chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endfunction

   // Memory model: asserts mem_ready after the configured number of wait cycles.
   initial begin
      int mcnt;
      int w;
      mcnt = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!mem_req) begin
            mcnt = 0;
            mem_ready = 1'b0;
         end else begin
            w = IorD ? data_wait : fetch_wait;
            if (mcnt >= w) begin
               mem_ready = 1'b1;
               mcnt = 0;
            end else begin
               mem_ready = 1'b0;
               mcnt++;
            end
         end
      end
   end

   // Monitor: per-instruction accumulation from FETCH entry to the retire/abort event.
   initial begin
      bit active;
      int lat, dreq, mw, rwe, pcw, irw, okind;
      vec_t e;
      active = 0;
      lat = 0; dreq = 0; mw = 0; rwe = 0; pcw = 0; irw = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("reset_outputs_zero",
                int'({mem_req, PCWrite, IorD, IRWrite, memWrite, regWriteEnable, memToReg,
                      regDst, ALUSrcA, ALUSrcB, PCSrc, ALUControl, instr_done, illegal_op,
                      mem_timeout}), 0);
            if (active) begin
               active = 0;
               if (sb.size() == 0) chk("abort_without_expectation", 1, 0);
               else begin
                  e = sb.pop_front();
                  chk("abort_kind", K_ABORT, e.kind);
                  $display("[TB] ins=%h aborted by reset after %0d cycles", e.ins, lat);
               end
            end
         end else begin
            if (!active && mem_req && !IorD) begin
               active = 1;
               lat = 0; dreq = 0; mw = 0; rwe = 0; pcw = 0; irw = 0;
            end
            if (active) begin
               lat++;
               if (mem_req && IorD) dreq++;
               if (memWrite) mw++;
               if (regWriteEnable) rwe++;
               if (PCWrite) pcw++;
               if (IRWrite) irw++;
               if (instr_done || illegal_op || mem_timeout) begin
                  active = 0;
                  okind = instr_done ? K_DONE : (illegal_op ? K_ILL : K_TO);
                  if (sb.size() == 0) chk("event_without_expectation", 1, 0);
                  else begin
                     e = sb.pop_front();
                     $display("[TB] ins=%h kind=%0d lat=%0d pcw=%0d rwe=%0d PCSrc=%0d",
                              e.ins, okind, lat, pcw, rwe, PCSrc);
                     chk("kind", okind, e.kind);
                     chk("latency", lat, e.lat);
                     chk("data_req_cycles", dreq, e.dreq);
                     chk("memwrite_cycles", mw, e.mw);
                     chk("regwrite_cycles", rwe, e.rwe);
                     chk("pcwrite_cycles", pcw, e.pcw);
                     chk("irwrite_cycles", irw, e.irw);
                     chk("pcsrc_at_retire", int'(PCSrc), e.pcsrc);
                     chk("memtoreg_at_retire", int'(memToReg), e.m2r);
                     chk("regdst_at_retire", int'(regDst), e.rdst);
                  end
               end
            end else if (instr_done || illegal_op || mem_timeout) begin
               chk("spurious_event", 1, 0);
            end
         end
      end
   end

   // Stimulus
   initial begin
      bit stop_run;
      bit seen;
      stop_run = 0;
      //            ins          fw    dw  bc kind    lat dreq mw rwe pcw irw pcsrc m2r rdst
      vecs[0]  = mk(32'h80000000, 0,    0, 0, K_DONE,   4, 0, 0, 1, 1, 1, 0, 0, 1);
      vecs[1]  = mk(32'h8C000000, 0,    3, 0, K_DONE,   8, 4, 0, 1, 1, 1, 0, 1, 0);
      vecs[2]  = mk(32'hAC000000, 0,    0, 0, K_DONE,   4, 1, 1, 0, 1, 1, 0, 0, 0);
      vecs[3]  = mk(32'h40000000, 0,    0, 1, K_DONE,   3, 0, 0, 0, 2, 1, 2, 0, 0);
      vecs[4]  = mk(32'h40000000, 0,    0, 0, K_DONE,   3, 0, 0, 0, 1, 1, 2, 0, 0);
      vecs[5]  = mk(32'h0C000000, 0,    0, 0, K_DONE,   3, 0, 0, 1, 2, 1, 1, 1, 0);
      vecs[6]  = mk(32'h20000000, 0,    0, 0, K_DONE,   3, 0, 0, 0, 2, 1, 3, 0, 0);
      vecs[7]  = mk(32'h38000000, 2,    0, 0, K_DONE,   6, 0, 0, 1, 1, 1, 0, 0, 0);
      vecs[8]  = mk(32'hFC000000, 0,    0, 0, K_ILL,    2, 0, 0, 0, 1, 1, 0, 0, 0);
      vecs[9]  = mk(32'h00000000, 1000, 0, 0, K_TO,   256, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[10] = mk(32'h08000000, 1,    0, 0, K_DONE,   5, 0, 0, 1, 1, 1, 0, 0, 1);
      vecs[11] = mk(32'hAC000000, 0, 1000, 0, K_ABORT,  0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[12] = mk(32'h80000000, 0,    0, 0, K_DONE,   4, 0, 0, 1, 1, 1, 0, 0, 1);

      repeat (3) @(negedge clk);
      #2 reset_n = 1'b1;

      for (int v = 0; v < NV && !stop_run; v++) begin
         fetch_wait = vecs[v].fw;
         sb.push_back(vecs[v]);
         if (vecs[v].kind != K_TO) begin
            seen = 0;
            for (int c = 0; c < 2000 && !seen; c++) begin
               @(negedge clk);
               if (IRWrite) seen = 1;
            end
            if (!seen) begin
               chk("fetch_wait_bound", 0, 1);
               stop_run = 1;
               break;
            end
            @(posedge clk);
            #1;
            ins = vecs[v].ins;
            data_wait = vecs[v].dw;
            branch_cond = vecs[v].bc;
         end
         if (vecs[v].kind == K_ABORT) begin
            seen = 0;
            for (int c = 0; c < 100 && !seen; c++) begin
               @(negedge clk);
               if (mem_req && IorD) seen = 1;
            end
            chk("reached_mem_acc", int'(seen), 1);
            chk("memwrite_before_reset", int'(memWrite), 1);
            @(negedge clk);
            #2 reset_n = 1'b0;
            #1;
            chk("memwrite_drop_on_reset", int'(memWrite), 0);
            chk("memreq_drop_on_reset", int'(mem_req), 0);
            repeat (2) @(negedge clk);
            #2 reset_n = 1'b1;
         end else begin
            seen = 0;
            for (int c = 0; c < 2000 && !seen; c++) begin
               @(negedge clk);
               if (instr_done || illegal_op || mem_timeout) seen = 1;
            end
            if (!seen) begin
               chk("retire_wait_bound", 0, 1);
               stop_run = 1;
            end
         end
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
